// File: rtl/usb_rx_packet_fifo.sv
// Receive byte FIFO with packet commit/rewind. Bytes become readable only after pkt_commit.
// Optional macro USB_RX_FIFO_STATS_EN adds a saturating dropped_count output.
module usb_rx_packet_fifo #(
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          write_enable,
    input  logic [7:0]    write_data,
    input  logic          pkt_commit,
    input  logic          pkt_abort,
    input  logic          read_enable,
    output logic [7:0]    read_data,
    output logic          fifo_empty,
    output logic          fifo_full,
    output logic [AW:0]   byte_count,
    output logic          pkt_dropped,
    output logic [1:0]    debug_state
`ifdef USB_RX_FIFO_STATS_EN
    ,
    output logic [7:0]    dropped_count
`endif
);

    // Handshake: a byte moves when its enable is high at a rising edge and the
    // FIFO can take it (write: !fifo_full and not OVFL; read: !fifo_empty).

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_OVFL = 2'd2
    } state_t;

    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] rd_ptr, cm_ptr, wr_ptr;
    logic [AW:0] wr_ptr_nxt, cm_ptr_nxt;
    state_t      state, state_nxt;
    logic        drop, wr_accept, rd_accept;

    assign fifo_empty  = (rd_ptr == cm_ptr);
    assign fifo_full   = ((wr_ptr - rd_ptr) == FULL_LEVEL);
    assign byte_count  = cm_ptr - rd_ptr;
    assign read_data   = mem[rd_ptr[AW-1:0]];
    assign debug_state = state;

    always_comb begin
        drop       = pkt_abort || (pkt_commit && (state == ST_OVFL));
        wr_accept  = write_enable && !fifo_full && (state != ST_OVFL) && !drop;
        rd_accept  = read_enable && !fifo_empty;
        wr_ptr_nxt = wr_ptr + (AW + 1)'(wr_accept);
        cm_ptr_nxt = cm_ptr;
        state_nxt  = state;
        if (drop) begin
            // Rewind the speculative pointer; the reader side is untouched.
            wr_ptr_nxt = cm_ptr;
            state_nxt  = ST_IDLE;
        end else if (pkt_commit) begin
            cm_ptr_nxt = wr_ptr_nxt;
            state_nxt  = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (write_enable) state_nxt = fifo_full ? ST_OVFL : ST_RECV;
                ST_RECV: if (write_enable && fifo_full) state_nxt = ST_OVFL;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_ptr      <= '0;
            cm_ptr      <= '0;
            wr_ptr      <= '0;
            state       <= ST_IDLE;
            pkt_dropped <= 1'b0;
        end else begin
            rd_ptr      <= rd_ptr + (AW + 1)'(rd_accept);
            cm_ptr      <= cm_ptr_nxt;
            wr_ptr      <= wr_ptr_nxt;
            state       <= state_nxt;
            pkt_dropped <= drop;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr[AW-1:0]] <= write_data;
    end

`ifdef USB_RX_FIFO_STATS_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dropped_count <= '0;
        end else if (pkt_dropped && (dropped_count != 8'hFF)) begin
            dropped_count <= dropped_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_usb_rx_packet_fifo.sv
// Self-checking bench for usb_rx_packet_fifo: commit/abort/overflow/wrap scenarios.
// Covers dropped_count as well when USB_RX_FIFO_STATS_EN is defined.
module tb_usb_rx_packet_fifo;

    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          n_rst;
    logic          write_enable, pkt_commit, pkt_abort, read_enable;
    logic [7:0]    write_data;
    logic [7:0]    read_data;
    logic          fifo_empty, fifo_full, pkt_dropped;
    logic [AW:0]   byte_count;
    logic [1:0]    debug_state;
`ifdef USB_RX_FIFO_STATS_EN
    logic [7:0]    dropped_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];   // committed bytes, in reader order
    logic [7:0] pend_q[$];  // bytes of the packet still being received

    usb_rx_packet_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .n_rst(n_rst), .write_enable(write_enable), .write_data(write_data),
        .pkt_commit(pkt_commit), .pkt_abort(pkt_abort), .read_enable(read_enable),
        .read_data(read_data), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .byte_count(byte_count), .pkt_dropped(pkt_dropped), .debug_state(debug_state)
`ifdef USB_RX_FIFO_STATS_EN
        , .dropped_count(dropped_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        write_enable = 1'b1;
        write_data   = b;
        pend_q.push_back(b);
        step();
        write_enable = 1'b0;
    endtask

    task automatic commit_pkt();
        pkt_commit = 1'b1;
        step();
        pkt_commit = 1'b0;
        while (pend_q.size() != 0) exp_q.push_back(pend_q.pop_front());
        check("commit_count", 32'(byte_count), exp_q.size());
    endtask

    task automatic abort_pkt();
        pkt_abort = 1'b1;
        step();
        pkt_abort = 1'b0;
        pend_q.delete();
        check("abort_dropped", 32'(pkt_dropped), 1);
    endtask

    task automatic read_one();
        check("read_not_empty", 32'(fifo_empty), 0);
        if (exp_q.size() != 0) check("read_data", 32'(read_data), 32'(exp_q.pop_front()));
        read_enable = 1'b1;
        step();
        read_enable = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        int n;
        n_rst = 1'b0; write_enable = 1'b0; write_data = '0;
        pkt_commit = 1'b0; pkt_abort = 1'b0; read_enable = 1'b0;
        repeat (3) step();
        check("rst_empty", 32'(fifo_empty), 1);
        check("rst_full", 32'(fifo_full), 0);
        check("rst_count", 32'(byte_count), 0);
        check("rst_dropped", 32'(pkt_dropped), 0);
        check("rst_state", 32'(debug_state), 0);
        n_rst = 1'b1;
        step();

        // Basic packet: invisible until commit.
        push_byte(8'hA1);
        check("state_recv", 32'(debug_state), 1);
        push_byte(8'hB2);
        push_byte(8'hC3);
        check("precommit_empty", 32'(fifo_empty), 1);
        check("precommit_count", 32'(byte_count), 0);
        commit_pkt();
        check("commit_state_idle", 32'(debug_state), 0);
        check("postcommit_empty", 32'(fifo_empty), 0);
        repeat (3) read_one();
        check("drained_empty", 32'(fifo_empty), 1);

        // Abort rewinds only the uncommitted bytes.
        push_byte(8'h11);
        push_byte(8'h22);
        commit_pkt();
        push_byte(8'h33); push_byte(8'h44); push_byte(8'h55);
        abort_pkt();
        check("abort_count", 32'(byte_count), 2);
        step();
        check("dropped_pulse_end", 32'(pkt_dropped), 0);
        push_byte(8'h66);
        push_byte(8'h77);
        commit_pkt();
        repeat (4) read_one();
        check("gap_empty", 32'(fifo_empty), 1);

        // Overflow: 64 bytes fill, 65th lost, commit becomes abort.
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i + 8'h80));
        check("ovf_full", 32'(fifo_full), 1);
        check("ovf_state_recv", 32'(debug_state), 1);
        write_enable = 1'b1; write_data = 8'hEE;
        step();
        write_enable = 1'b0;
        check("ovf_state_ovfl", 32'(debug_state), 2);
        pkt_commit = 1'b1;
        step();
        pkt_commit = 1'b0;
        pend_q.delete();
        check("ovf_dropped", 32'(pkt_dropped), 1);
        check("ovf_count", 32'(byte_count), 0);
        check("ovf_full_clear", 32'(fifo_full), 0);
        check("ovf_state_idle", 32'(debug_state), 0);
        check("ovf_empty", 32'(fifo_empty), 1);

        // Wrap: 200 single-byte packets written+committed in one cycle, random reads.
        for (int p = 0; p < 200; p++) begin
            b = 8'($urandom_range(0, 255));
            if (exp_q.size() != 0 && (exp_q.size() >= 60 || $urandom_range(0, 1) == 1)) begin
                check("wrap_data", 32'(read_data), 32'(exp_q.pop_front()));
                read_enable = 1'b1;
            end
            write_enable = 1'b1; write_data = b; pkt_commit = 1'b1;
            step();
            write_enable = 1'b0; pkt_commit = 1'b0; read_enable = 1'b0;
            exp_q.push_back(b);
            check("wrap_count", 32'(byte_count), exp_q.size());
            check("wrap_le_depth", 32'(byte_count <= DEPTH), 1);
        end

        // Commit and abort together: abort wins, same-cycle write discarded.
        n = exp_q.size();
        push_byte(8'h5A);
        write_enable = 1'b1; write_data = 8'hA5; pkt_commit = 1'b1; pkt_abort = 1'b1;
        step();
        write_enable = 1'b0; pkt_commit = 1'b0; pkt_abort = 1'b0;
        pend_q.delete();
        check("ca_dropped", 32'(pkt_dropped), 1);
        check("ca_count", 32'(byte_count), n);
        check("ca_state", 32'(debug_state), 0);
        commit_pkt();
        check("empty_commit_dropped", 32'(pkt_dropped), 0);

`ifdef USB_RX_FIFO_STATS_EN
        check("stats_three", 32'(dropped_count), 3);
        for (int i = 0; i < 300; i++) begin
            pkt_abort = 1'b1;
            step();
        end
        pkt_abort = 1'b0;
        step();
        check("stats_saturate", 32'(dropped_count), 255);
`endif

        while (exp_q.size() != 0) read_one();
        check("final_empty", 32'(fifo_empty), 1);
        check("final_count", 32'(byte_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
